// File: rtl/bcd4221_final_adder_serial.sv
// Digit-serial final carry-propagate adder for the decimal multiplier.
// Adds the BCD-4221 redundant sum/carry pair (S, H) one digit per clock,
// least significant digit first, and produces the BCD-8421 product P with
// a decimal carry out.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. On the input side in_ready is high only in IDLE, and in_valid
// is ignored in any other state. On the output side out_valid stays high,
// with P/cout frozen, until out_ready is sampled high.
module bcd4221_final_adder_serial #(
    parameter int NDIG = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] S,
    input  logic [4*NDIG-1:0] H,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] P,
    output logic              cout,
    output logic [1:0]        state_dbg
);

    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              c_q, c_d;
    logic              cout_q, cout_d;
    logic [4*NDIG-1:0] s_q, s_d;
    logic [4*NDIG-1:0] h_q, h_d;
    logic [4*NDIG-1:0] p_q, p_d;

    logic [3:0] s_dig;
    logic [3:0] h_dig;
    logic [4:0] t_sum;
    logic [4:0] t_mod;
    logic       t_carry;

    // 4221 weights: 4*b3 + 2*b2 + 2*b1 + b0; every code maps into 0..9.
    function automatic logic [3:0] val4221(input logic [3:0] d);
        return {1'b0, d[3], 2'b00} + {2'b00, d[2], 1'b0}
             + {2'b00, d[1], 1'b0} + {3'b000, d[0]};
    endfunction

    assign s_dig = s_q[4*int'(cnt_q) +: 4];
    assign h_dig = h_q[4*int'(cnt_q) +: 4];

    // One decimal digit position: t in 0..19, digit = t mod 10, carry = t >= 10.
    always_comb begin
        t_sum   = {1'b0, val4221(s_dig)} + {1'b0, val4221(h_dig)} + {4'b0000, c_q};
        t_carry = (t_sum >= 5'd10);
        t_mod   = t_carry ? (t_sum - 5'd10) : t_sum;
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        s_d     = s_q;
        h_d     = h_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d     = S;
                    h_d     = H;
                    cnt_d   = '0;
                    c_d     = 1'b0;
                    cout_d  = 1'b0;
                    p_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                p_d[4*int'(cnt_q) +: 4] = t_mod[3:0];
                c_d = t_carry;
                if (cnt_q == CW'(NDIG - 1)) begin
                    // Last digit: the counter stays put so it never passes NDIG-1.
                    cout_d  = t_carry;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            s_q     <= '0;
            h_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            s_q     <= s_d;
            h_q     <= h_d;
            p_q     <= p_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign P         = p_q;
    assign cout      = cout_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd4221_final_adder_serial.sv
// Directed bench for bcd4221_final_adder_serial with hand-computed results.
module tb_bcd4221_final_adder_serial;

    localparam int NDIG = 11;
    localparam int W    = 4 * NDIG;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] s_in;
    logic [W-1:0] h_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] p_out;
    logic         cout;
    logic [1:0]   state_dbg;

    int tests;
    int fails;
    int lat;

    bcd4221_final_adder_serial #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (s_in),
        .H         (h_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (p_out),
        .cout      (cout),
        .state_dbg (state_dbg)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operand pair and let it be accepted on the next edge.
    task automatic send(input logic [W-1:0] s, input logic [W-1:0] h);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_in_ready", {63'd0, in_ready}, 64'd1);
        s_in     = s;
        h_in     = h;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        s_in     = '1;
        h_in     = '1;
        check("accept_in_ready_low", {63'd0, in_ready}, 64'd0);
    endtask

    // Count edges from the accept edge until out_valid is seen.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        s_in      = '0;
        h_in      = '0;
        #12;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_p", {20'd0, p_out}, 64'd0);
        check("reset_cout", {63'd0, cout}, 64'd0);
        rst_n = 1'b1;
        tick();

        // 5 + 5 in digit 0 -> 10, carry into digit 1.
        send(44'h7, 44'h9);
        wait_valid(lat);
        check("t1_latency", 64'(lat), 64'd11);
        check("t1_p", {20'd0, p_out}, 64'h10);
        check("t1_cout", {63'd0, cout}, 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_idle_out_valid", {63'd0, out_valid}, 64'd0);
        check("t1_idle_in_ready", {63'd0, in_ready}, 64'd1);

        // 99999999999 + 1: carry ripples through every digit.
        send(44'hFFFFFFFFFFF, 44'h1);
        wait_valid(lat);
        check("t2_latency", 64'(lat), 64'd11);
        check("t2_p", {20'd0, p_out}, 64'h0);
        check("t2_cout", {63'd0, cout}, 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Redundant codes 0110 and 1000 both mean 4 in digit 3.
        send(44'h6005, 44'h2003);
        wait_valid(lat);
        check("t3a_p", {20'd0, p_out}, 64'h6006);
        check("t3a_cout", {63'd0, cout}, 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send(44'h8005, 44'h2003);
        wait_valid(lat);
        check("t3b_p", {20'd0, p_out}, 64'h6006);
        check("t3b_cout", {63'd0, cout}, 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Backpressure: result held, new operands ignored while in DONE.
        send(44'h4, 44'h4);
        wait_valid(lat);
        check("t4_latency", 64'(lat), 64'd11);
        in_valid = 1'b1;
        s_in     = 44'hFFFFFFFFFFF;
        h_in     = 44'hFFFFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("t4_hold_in_ready", {63'd0, in_ready}, 64'd0);
            check("t4_hold_p", {20'd0, p_out}, 64'h4);
            check("t4_hold_cout", {63'd0, cout}, 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t4_release_out_valid", {63'd0, out_valid}, 64'd0);
        check("t4_release_in_ready", {63'd0, in_ready}, 64'd1);

        // Reset in the middle of a run at cnt = 4.
        send(44'h12345678901, 44'h98765432109);
        for (int i = 0; i < 4; i++) tick();
        check("t5_mid_run_out_valid", {63'd0, out_valid}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("t5_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("t5_rst_p", {20'd0, p_out}, 64'h0);
        check("t5_rst_cout", {63'd0, cout}, 64'd0);
        rst_n = 1'b1;
        tick();
        // 0011 = 3 and 1000 = 4 -> 7.
        send(44'h3, 44'h8);
        wait_valid(lat);
        check("t5_latency", 64'(lat), 64'd11);
        check("t5_p", {20'd0, p_out}, 64'h7);
        check("t5_cout", {63'd0, cout}, 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        s_in      = 44'hF0F;
        h_in      = 44'h10B;
        in_valid  = 1'b1;
        tick();
        check("t6_first_accept", {63'd0, in_ready}, 64'd0);
        s_in = 44'hEEEEEEEEEEE;
        h_in = 44'h00000000007;
        wait_valid(lat);
        check("t6a_latency", 64'(lat), 64'd11);
        check("t6a_p", {20'd0, p_out}, 64'h1016);
        check("t6a_cout", {63'd0, cout}, 64'd0);
        tick();
        check("t6_gap_out_valid", {63'd0, out_valid}, 64'd0);
        check("t6_gap_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        check("t6_second_accept", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        wait_valid(lat);
        check("t6b_latency", 64'(lat), 64'd11);
        check("t6b_p", {20'd0, p_out}, 64'h88888888893);
        check("t6b_cout", {63'd0, cout}, 64'd0);
        tick();
        out_ready = 1'b0;
        check("t6b_done_out_valid", {63'd0, out_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
